// File: rtl/dot11_tx_encoder_pkg.sv
// rtl/dot11_tx_encoder_pkg.sv - state codes, rate codes and rate lookup for the 802.11a/g TX bit pipeline
package dot11_tx_encoder_pkg;

  typedef enum logic [2:0] {
    S_TX_IDLE    = 3'd0,
    S_TX_SERVICE = 3'd1,
    S_TX_DATA    = 3'd2,
    S_TX_TAIL    = 3'd3,
    S_TX_PAD     = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    PUNCT_12 = 2'd0,
    PUNCT_23 = 2'd1,
    PUNCT_34 = 2'd2
  } punct_t;

  localparam logic [3:0] RATE_6  = 4'b1011;
  localparam logic [3:0] RATE_9  = 4'b1111;
  localparam logic [3:0] RATE_12 = 4'b1010;
  localparam logic [3:0] RATE_18 = 4'b1110;
  localparam logic [3:0] RATE_24 = 4'b1001;
  localparam logic [3:0] RATE_36 = 4'b1101;
  localparam logic [3:0] RATE_48 = 4'b1000;
  localparam logic [3:0] RATE_54 = 4'b1100;

  localparam logic [6:0] DEFAULT_SEED = 7'b1011101;

  typedef struct packed {
    logic [7:0] n_dbps;
    punct_t     punct;
  } rate_cfg_t;

  function automatic rate_cfg_t rate_lookup(input logic [3:0] rate);
    rate_cfg_t cfg;
    case (rate)
      RATE_9:  cfg = '{n_dbps: 8'd36,  punct: PUNCT_34};
      RATE_12: cfg = '{n_dbps: 8'd48,  punct: PUNCT_12};
      RATE_18: cfg = '{n_dbps: 8'd72,  punct: PUNCT_34};
      RATE_24: cfg = '{n_dbps: 8'd96,  punct: PUNCT_12};
      RATE_36: cfg = '{n_dbps: 8'd144, punct: PUNCT_34};
      RATE_48: cfg = '{n_dbps: 8'd192, punct: PUNCT_23};
      RATE_54: cfg = '{n_dbps: 8'd216, punct: PUNCT_34};
      default: cfg = '{n_dbps: 8'd24,  punct: PUNCT_12};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/dot11_tx_encoder_conv.sv
// rtl/dot11_tx_encoder_conv.sv - K=7 rate-1/2 convolutional encoder (133/171 octal)
module conv_encoder_k7 (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic bit_in,
  input  logic strobe,
  output logic a,
  output logic b
);

  // hist[5] is the previous input bit, hist[0] the one six bits back
  logic [5:0] hist;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else if (clear) begin
      hist <= '0;
    end else if (strobe) begin
      hist <= {bit_in, hist[5:1]};
    end
  end

  assign a = ^(7'o133 & {bit_in, hist});
  assign b = ^(7'o171 & {bit_in, hist});

endmodule

// File: rtl/dot11_tx_encoder.sv
// rtl/dot11_tx_encoder.sv - DATA field builder: scramble, K=7 encode and puncture to a serial coded stream
module dot11_tx_encoder
  import dot11_tx_encoder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [3:0]  rate,
  input  logic [11:0] len,
  input  logic [6:0]  seed,
  input  logic        scramble_bypass,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_strobe,
  output logic        byte_in_ready,
  output logic        coded_out,
  output logic        coded_out_strobe,
  input  logic        coded_out_ready,
  output logic        busy,
  output logic        done
);

  tx_state_t  state, state_nx;
  rate_cfg_t  cfg_in;
  logic [7:0] n_dbps;
  punct_t     punct;
  logic       bypass;
  logic [11:0] len_r;
  logic [11:0] bytes_left;
  logic [6:0] scr;
  logic [7:0] sreg;
  logic [3:0] sh_cnt;
  logic [4:0] cnt;
  logic [7:0] sym_cnt;
  logic [7:0] sym_next;
  logic [1:0] phase;
  logic       sub;
  logic       done_r;

  logic start_ok, have_bit, src_bit, fb, enc_bit, enc_a, enc_b;
  logic two_out, last_sub, cur_bit, xfer, adv, load, frame_end, phase_wrap;

  assign cfg_in   = rate_lookup(rate);
  assign start_ok = enable && start && (state == S_TX_IDLE) && !done_r;

  assign have_bit = (state inside {S_TX_SERVICE, S_TX_TAIL, S_TX_PAD}) ||
                    ((state == S_TX_DATA) && (sh_cnt != 4'd0));
  assign src_bit  = (state == S_TX_DATA) ? sreg[0] : 1'b0;
  assign fb       = scr[6] ^ scr[3];
  // Tail bits are zeroed after scrambling so the encoder flushes to the all-zero state
  assign enc_bit  = (state == S_TX_TAIL) ? 1'b0 : (bypass ? src_bit : (src_bit ^ fb));

  conv_encoder_k7 u_enc (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok),
    .bit_in (enc_bit),
    .strobe (adv),
    .a      (enc_a),
    .b      (enc_b)
  );

  // Puncturing: phase 0 of every period keeps A and B; later phases keep one bit
  assign two_out  = (punct == PUNCT_12) || (phase == 2'd0);
  assign last_sub = !two_out || sub;
  assign cur_bit  = sub ? enc_b : (((punct == PUNCT_34) && (phase == 2'd2)) ? enc_b : enc_a);
  assign phase_wrap = (punct == PUNCT_12) ||
                      ((punct == PUNCT_23) && (phase == 2'd1)) ||
                      ((punct == PUNCT_34) && (phase == 2'd2));

  assign coded_out_strobe = enable && have_bit;
  assign coded_out        = coded_out_strobe && cur_bit;
  assign xfer             = coded_out_strobe && coded_out_ready;
  assign adv              = xfer && last_sub;
  assign sym_next         = (sym_cnt == n_dbps - 8'd1) ? 8'd0 : sym_cnt + 8'd1;

  // A byte may land in the same cycle the last buffered bit leaves
  assign byte_in_ready = enable && (state == S_TX_DATA) && (bytes_left != 12'd0) &&
                         ((sh_cnt == 4'd0) || ((sh_cnt == 4'd1) && adv));
  assign load          = byte_in_ready && byte_in_strobe;

  assign frame_end = adv && (((state == S_TX_TAIL) && (cnt == 5'd5) && (sym_next == 8'd0)) ||
                             ((state == S_TX_PAD) && (sym_next == 8'd0)));
  assign busy = (state != S_TX_IDLE) || done_r;
  assign done = done_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_TX_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_TX_IDLE:    if (start_ok) state_nx = S_TX_SERVICE;
      S_TX_SERVICE: if (adv && (cnt == 5'd15)) state_nx = (len_r == 12'd0) ? S_TX_TAIL : S_TX_DATA;
      S_TX_DATA:    if (adv && (sh_cnt == 4'd1) && !load && (bytes_left == 12'd0)) state_nx = S_TX_TAIL;
      S_TX_TAIL:    if (adv && (cnt == 5'd5)) state_nx = (sym_next == 8'd0) ? S_TX_IDLE : S_TX_PAD;
      S_TX_PAD:     if (adv && (sym_next == 8'd0)) state_nx = S_TX_IDLE;
      default:      state_nx = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_dbps     <= '0;
      punct      <= PUNCT_12;
      bypass     <= 1'b0;
      len_r      <= '0;
      bytes_left <= '0;
      scr        <= '0;
      sreg       <= '0;
      sh_cnt     <= '0;
      cnt        <= '0;
      sym_cnt    <= '0;
      phase      <= '0;
      sub        <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= frame_end;
      if (start_ok) begin
        n_dbps     <= cfg_in.n_dbps;
        punct      <= cfg_in.punct;
        bypass     <= scramble_bypass;
        len_r      <= len;
        bytes_left <= len;
        scr        <= (seed == 7'd0) ? DEFAULT_SEED : seed;
        sh_cnt     <= '0;
        cnt        <= '0;
        sym_cnt    <= '0;
        phase      <= '0;
        sub        <= 1'b0;
      end else begin
        if (xfer) sub <= !last_sub;
        if (adv) begin
          scr     <= {scr[5:0], fb};
          sym_cnt <= sym_next;
          phase   <= phase_wrap ? 2'd0 : phase + 2'd1;
          cnt     <= (state_nx != state) ? 5'd0 : cnt + 5'd1;
          if (state == S_TX_DATA) begin
            sreg   <= sreg >> 1;
            sh_cnt <= sh_cnt - 4'd1;
          end
        end
        if (load) begin
          sreg       <= byte_in;
          sh_cnt     <= 4'd8;
          bytes_left <= bytes_left - 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot11_tx_encoder.sv
// tb/tb_dot11_tx_encoder.sv - directed self-checking bench for dot11_tx_encoder
module tb_dot11_tx_encoder;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] len;
  logic [6:0]  seed;
  logic        scramble_bypass;
  logic [7:0]  byte_in;
  logic        byte_in_strobe;
  logic        byte_in_ready;
  logic        coded_out;
  logic        coded_out_strobe;
  logic        coded_out_ready;
  logic        busy;
  logic        done;

  dot11_tx_encoder dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .start            (start),
    .rate             (rate),
    .len              (len),
    .seed             (seed),
    .scramble_bypass  (scramble_bypass),
    .byte_in          (byte_in),
    .byte_in_strobe   (byte_in_strobe),
    .byte_in_ready    (byte_in_ready),
    .coded_out        (coded_out),
    .coded_out_strobe (coded_out_strobe),
    .coded_out_ready  (coded_out_ready),
    .busy             (busy),
    .done             (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests;
  int fails;

  logic       got      [0:2047];
  logic       exp_bits [0:2047];
  logic       ref_bits [0:2047];
  logic [7:0] payload  [0:63];
  int n_got, n_exp, n_ref;
  int pidx, done_at, done_cnt, hold_viol, ref_pidx;
  logic first_busy, first_strobe, busy_after;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_frame(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd,
                           input logic byp, input int stall, input int gap, input int abort_at);
    logic prev_hold;
    logic prev_bit;
    n_got = 0; pidx = 0; done_at = -1; done_cnt = 0; prev_hold = 1'b0; prev_bit = 1'b0;
    busy_after = 1'bx;
    @(negedge clock);
    start = 1'b1; rate = r; len = l; seed = sd; scramble_bypass = byp;
    coded_out_ready = 1'b0; byte_in_strobe = 1'b0;
    @(negedge clock);
    start = 1'b0;
    first_busy = busy;
    first_strobe = coded_out_strobe;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      coded_out_ready = (int'($urandom_range(99)) >= stall);
      byte_in_strobe  = (int'($urandom_range(99)) >= gap);
      byte_in         = payload[pidx[5:0]];
      #1;
      if (prev_hold && !(coded_out_strobe && (coded_out === prev_bit))) hold_viol++;
      prev_hold = coded_out_strobe && !coded_out_ready;
      prev_bit  = coded_out;
      if (coded_out_strobe && coded_out_ready && n_got < 2048) begin
        got[n_got] = coded_out;
        n_got++;
      end
      if (byte_in_strobe && byte_in_ready) pidx++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n_got;
      end else if (done_at >= 0) begin
        busy_after = busy;
        break;
      end
      if (abort_at > 0 && n_got == abort_at) break;
      @(negedge clock);
    end
    byte_in_strobe = 1'b0;
  endtask

  task automatic model_frame(input logic [3:0] r, input int l, input logic [6:0] sd, input logic byp);
    int ndbps, cls, nsrc;
    logic [6:0] s;
    logic [5:0] h;
    logic [6:0] w;
    logic raw, f, x, a, b;
    case (r)
      4'b1111: begin ndbps = 36;  cls = 34; end
      4'b1010: begin ndbps = 48;  cls = 12; end
      4'b1110: begin ndbps = 72;  cls = 34; end
      4'b1001: begin ndbps = 96;  cls = 12; end
      4'b1101: begin ndbps = 144; cls = 34; end
      4'b1000: begin ndbps = 192; cls = 23; end
      4'b1100: begin ndbps = 216; cls = 34; end
      default: begin ndbps = 24;  cls = 12; end
    endcase
    nsrc = 0;
    while (nsrc < 22 + 8 * l) nsrc += ndbps;
    s = sd; h = '0; n_exp = 0;
    for (int k = 0; k < nsrc; k++) begin
      raw = (k >= 16 && k < 16 + 8 * l) ? payload[(k - 16) / 8][(k - 16) % 8] : 1'b0;
      f = s[6] ^ s[3];
      s = {s[5:0], f};
      x = byp ? raw : (raw ^ f);
      if (k >= 16 + 8 * l && k < 22 + 8 * l) x = 1'b0;
      w = {x, h};
      a = ^(w & 7'o133);
      b = ^(w & 7'o171);
      h = {x, h[5:1]};
      if (cls == 12 || (cls == 34 && k % 3 == 0) || (cls == 23 && k % 2 == 0)) begin
        exp_bits[n_exp] = a; exp_bits[n_exp + 1] = b; n_exp += 2;
      end else if ((cls == 34 && k % 3 == 2)) begin
        exp_bits[n_exp] = b; n_exp++;
      end else begin
        exp_bits[n_exp] = a; n_exp++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < n_exp && i < 2048; i++) if (got[i] !== exp_bits[i]) mism++;
    check({tag, "_len"}, n_got, n_exp);
    check({tag, "_bits"}, mism, 0);
  endtask

  initial begin
    logic [13:0] imp;
    logic [15:0] first16;
    int ones, mism;
    tests = 0; fails = 0; hold_viol = 0;
    reset = 1'b0; enable = 1'b1; start = 1'b0; rate = '0; len = '0; seed = '0;
    scramble_bypass = 1'b0; byte_in = '0; byte_in_strobe = 1'b0; coded_out_ready = 1'b0;
    for (int i = 0; i < 64; i++) payload[i] = 8'(i * 37 + 5);

    repeat (3) @(negedge clock);
    #1;
    check("reset_outputs", {coded_out, coded_out_strobe, byte_in_ready, busy, done}, 5'b0);
    @(negedge clock);
    reset = 1'b1;

    enable = 1'b0; start = 1'b1; rate = 4'b1011;
    @(negedge clock);
    start = 1'b0;
    check("enable_low_start", busy, 1'b0);
    enable = 1'b1;

    // Zero-length frame, bypassed scrambler: one 6 Mb/s symbol of zeros
    run_frame(4'b1011, 12'd0, 7'd0, 1'b1, 0, 0, 0);
    check("start_busy", first_busy, 1'b1);
    check("start_strobe", first_strobe, 1'b1);
    check("len0_count", n_got, 48);
    ones = 0;
    for (int i = 0; i < 48; i++) ones += int'(got[i]);
    check("len0_zeros", ones, 0);
    check("len0_done_at", done_at, 48);
    check("len0_done_pulses", done_cnt, 1);
    check("len0_busy_after", busy_after, 1'b0);

    // Encoder impulse response from a single data bit
    payload[0] = 8'h01;
    run_frame(4'b1011, 12'd1, 7'd0, 1'b1, 0, 0, 0);
    check("imp_count", n_got, 96);
    for (int i = 0; i < 14; i++) imp[13 - i] = got[32 + i];
    check("imp_bits", imp, 14'b11011111001011);
    check("imp_tail", {got[46], got[47]}, 2'b00);
    ones = 0;
    for (int i = 0; i < 96; i++) ones += int'(got[i]);
    check("imp_ones", ones, 10);
    payload[0] = 8'd5;

    // Scrambler, seed all ones: SERVICE pre-encode bits 0000_1110
    run_frame(4'b1011, 12'd0, 7'h7F, 1'b0, 0, 0, 0);
    for (int i = 0; i < 16; i++) first16[15 - i] = got[i];
    check("scr_first16", first16, 16'b0000000011100101);
    model_frame(4'b1011, 0, 7'h7F, 1'b0);
    check_model("scr_frame");

    run_frame(4'b1011, 12'd0, 7'd0, 1'b0, 0, 0, 0);
    model_frame(4'b1011, 0, 7'b1011101, 1'b0);
    check_model("seed0_default");

    // Puncturing at 3/4 and 2/3
    run_frame(4'b1111, 12'd10, 7'h5A, 1'b0, 0, 0, 0);
    check("p34_count", n_got, 144);
    model_frame(4'b1111, 10, 7'h5A, 1'b0);
    check_model("p34");

    run_frame(4'b1000, 12'd10, 7'h5A, 1'b0, 0, 0, 0);
    check("p23_count", n_got, 288);
    model_frame(4'b1000, 10, 7'h5A, 1'b0);
    check_model("p23");

    // Backpressure and byte gaps must not alter the stream
    run_frame(4'b1110, 12'd12, 7'h33, 1'b0, 0, 0, 0);
    for (int i = 0; i < n_got; i++) ref_bits[i] = got[i];
    n_ref = n_got;
    ref_pidx = pidx;
    check("bp_ref_bytes", ref_pidx, 12);
    run_frame(4'b1110, 12'd12, 7'h33, 1'b0, 40, 50, 0);
    check("bp_count", n_got, n_ref);
    mism = 0;
    for (int i = 0; i < n_ref; i++) if (got[i] !== ref_bits[i]) mism++;
    check("bp_stream_equal", mism, 0);
    check("bp_bytes", pidx, 12);
    check("bp_done_pulses", done_cnt, 1);
    model_frame(4'b1110, 12, 7'h33, 1'b0);
    check_model("bp_model");
    check("hold_stable", hold_viol, 0);

    // Asynchronous reset mid-frame at 54 Mb/s, then a clean frame
    run_frame(4'b1100, 12'd20, 7'h21, 1'b0, 0, 0, 100);
    check("abort_count", n_got, 100);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs", {coded_out, coded_out_strobe, byte_in_ready, busy, done}, 5'b0);
    @(negedge clock);
    reset = 1'b1;
    run_frame(4'b1100, 12'd20, 7'h21, 1'b0, 0, 0, 0);
    check("r54_count", n_got, 288);
    check("r54_done_pulses", done_cnt, 1);
    model_frame(4'b1100, 20, 7'h21, 1'b0);
    check_model("r54");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
